bmat_issue_wb: RTL and testbench
================================

// Module: bmat_issue_wb
// PURPOSE
//   Issue/writeback wrapper stage around the registered 64-bit bit-matrix multiply core (1-cycle latency, no handshake).
//   Accepts bmat requests over valid/ready and drives the core's xoren/rs1/rs2 in the issue cycle.
//   Captures core rd one cycle later, tags it, and buffers it in a result FIFO with valid/ready to writeback.
//   Issue is credit-based, so a result is never dropped under backpressure.
// PARAMETERS
//   TAG_W  5  width of request tag returned with the result
//   DEPTH  4  result FIFO entries; legal 3..16; DEPTH>=3 required for 1/cycle sustained throughput
// PORTS
//   clock      in   1      rising-edge clock
//   reset      in   1      synchronous, active-high reset
//   in_valid   in   1      request valid
//   in_ready   out  1      stage can accept a request this cycle
//   in_xor     in   1      1 = bmatxor (parity reduce), 0 = bmator (OR reduce)
//   in_rs1     in   64     matrix A, byte k = row k
//   in_rs2     in   64     matrix B
//   in_tag     in   TAG_W  request tag
//   core_xoren out  1      to core xoren
//   core_rs1   out  64     to core rs1
//   core_rs2   out  64     to core rs2
//   core_rd    in   64     from core rd (registered, valid cycle after issue)
//   out_valid  out  1      result valid (FIFO head)
//   out_ready  in   1      writeback accepts result
//   out_rd     out  64     result data
//   out_tag    out  TAG_W  tag of the result
//   busy       out  1      any request in flight or buffered
// BEHAVIOUR
//   - fire = in_valid & in_ready; pop = out_valid & out_ready.
//   - in_ready = ~reset & ((count + issue_d) < DEPTH); no same-cycle credit from pop (no out_ready->in_ready path).
//   - core_xoren/rs1/rs2 = fire ? in_xor/in_rs1/in_rs2 : 0; combinational, so core samples in the fire cycle.
//   - Registers issue_d <= fire and tag_d <= in_tag at every posedge. Cycle t+1: if issue_d, push {core_rd, tag_d}.
//   - Latency: fire in cycle t -> out_valid=1 in cycle t+2 (FIFO registered, no bypass).
//   - FIFO: wr_ptr/rd_ptr wrap modulo DEPTH; count 0..DEPTH.
//     Push+pop in the same cycle leaves count unchanged, including at count==DEPTH-1 and count==1.
//     Overflow is impossible by credit; an assertion checks push & count==DEPTH never occurs.
//     out_valid = count!=0. out_rd/out_tag = head entry; 0 when empty.
//   - Ordering: results leave in issue order; tags are opaque and never reordered or checked.
//   - out_valid & ~out_ready holds out_rd/out_tag stable until pop.
//   - busy = issue_d | (count!=0).
//   - Reset: count, pointers, issue_d, tag_d <= 0. During reset: in_ready=0, out_valid=0, busy=0, core_* = 0.
//     Cycle after reset deasserts: in_ready=1.
//   - Reset mid-operation: buffered results are discarded. A core_rd arriving the cycle after reset is ignored (issue_d cleared).
//   - in_valid may drop without fire; request fields are don't-care when ~in_valid.
// STRUCTURE
//   - Package bmat_pkg: localparam XLEN=64; typedef enum logic {BMAT_OR=0, BMAT_XOR=1} bmat_op_e;
//     typedef struct packed {logic [XLEN-1:0] rd; logic [TAG_W-1:0] tag;} bmat_res_t (tag width fixed at 5 in the package).
//   - Sub-module bmat_res_fifo (DEPTH, payload width): flop-array FIFO with push/pop/count/head.
//     The top level holds the credit logic, the issue_d/tag_d pipe and the core drive.
// TESTING
//   1. Reset held 3 cycles with in_valid=1 -> in_ready=0, out_valid=0, core_* = 0; cycle after release, in_ready=1.
//   2. Single bmatxor, rs1=rs2=64'h8040201008040201 (identity), tag=3, fire at t
//      -> out_valid at t+2, out_rd=identity, out_tag=3. Repeat as bmator with the same result.
//   3. Stream 20 back-to-back requests, out_ready=1, DEPTH=4 -> one fire per cycle, no in_ready drop, tags 0..19 in order.
//   4. out_ready=0, continuous in_valid -> exactly DEPTH fires then in_ready=0.
//      Raise out_ready -> DEPTH results pop in order, then issue resumes.
//   5. Fill to count=DEPTH-1, push and pop in one cycle -> count unchanged, head advances, no assertion.
//   6. Fire a request, assert reset in cycle t+1 -> core_rd ignored.
//      After release: out_valid=0, busy=0; a new request returns only its own tag.

Source files
------------

// File: rtl/bmat_pkg.sv
// Package: bmat_pkg
// Purpose: shared types and constants for the bit-matrix multiply issue/writeback
//          slice. Holds the datapath width, the reduce-operation encoding and the
//          packed result record that travels through the result FIFO.
// Contents:
//   XLEN        - datapath width of the bit-matrix operands and result
//   BMAT_TAG_W  - default width of the opaque request tag
//   bmat_op_e   - reduce operation (OR reduce vs parity reduce)
//   bmat_res_t  - {rd, tag} record as stored in the result buffer
package bmat_pkg;

    localparam int XLEN       = 64;
    localparam int BMAT_TAG_W = 5;

    typedef enum logic {
        BMAT_OR  = 1'b0,
        BMAT_XOR = 1'b1
    } bmat_op_e;

    typedef struct packed {
        logic [XLEN-1:0]       rd;
        logic [BMAT_TAG_W-1:0] tag;
    } bmat_res_t;

endpackage

// File: rtl/bmat_issue_wb_fifo.sv
// Module: bmat_res_fifo
// Purpose: flop-array result FIFO for the bit-matrix writeback path. Entries are
//          written at the tail on push and read from the head on pop; the head is
//          presented combinationally and forced to zero while the FIFO is empty.
// Ports:
//   clock        in   rising-edge clock
//   reset        in   synchronous active-high reset (pointers and count only)
//   push_i       in   write push_data_i at the tail this cycle
//   pop_i        in   retire the head entry this cycle (ignored when empty)
//   push_data_i  in   W-bit payload to store
//   count_o      out  number of valid entries, 0..DEPTH
//   head_o       out  payload at the head, zero when empty
module bmat_res_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 69
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [W-1:0]                 push_data_i,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic [W-1:0]                 head_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_pop;

    // Pointers wrap explicitly so that non-power-of-two depths work.
    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop = pop_i && (count_q != '0);

    // Pointer, count and storage update. A simultaneous push and pop leaves the
    // count untouched at any fill level, including the full-minus-one and single
    // entry cases. Storage itself is not reset; the empty check masks stale data.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= nextPtr(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= nextPtr(rd_ptr_q);
            end
            case ({push_i, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // The upstream credit scheme must never let a push land on a full buffer.
    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (!(push_i && (count_q == CW'(DEPTH))));
        end
    end

    assign count_o = count_q;
    assign head_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/bmat_issue_wb.sv
// Module: bmat_issue_wb
// Purpose: issue/writeback wrapper around a registered 64-bit bit-matrix multiply
//          core (1-cycle latency, no handshake). Requests are accepted over
//          valid/ready and driven to the core in the accept cycle; the core result
//          is captured the following cycle, tagged and buffered for writeback.
//          Issue is credit-based, so results are never lost under backpressure.
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   request handshake
//   in_xor              1 = parity reduce (bmatxor), 0 = OR reduce (bmator)
//   in_rs1/in_rs2       operand matrices (byte k = row k)
//   in_tag              opaque request tag returned with the result
//   core_xoren/rs1/rs2  operands to the core, zero unless a request is accepted
//   core_rd             core result, valid the cycle after issue
//   out_valid/out_ready result handshake (FIFO head)
//   out_rd/out_tag      result data and tag, zero when nothing is buffered
//   busy                a request is in flight or a result is buffered
module bmat_issue_wb
    import bmat_pkg::*;
#(
    parameter int TAG_W = BMAT_TAG_W,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_xor,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             core_xoren,
    output logic [XLEN-1:0]  core_rs1,
    output logic [XLEN-1:0]  core_rs2,
    input  logic [XLEN-1:0]  core_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_rd,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int SW = CW + 1;
    localparam int W  = XLEN + TAG_W;

    logic             issue_q;
    logic [TAG_W-1:0] tag_q;
    logic [CW-1:0]    count;
    logic [W-1:0]     head;
    logic [SW-1:0]    credit_used;
    logic             fire;
    logic             pop;
    logic             has_data;
    bmat_op_e         op;

    // Credits cover buffered results plus the one result the core is producing.
    // Pops deliberately do not return credit in the same cycle, which keeps
    // out_ready off any combinational path to in_ready.
    assign credit_used = {1'b0, count} + SW'(issue_q);
    assign in_ready    = ~reset & (credit_used < SW'(DEPTH));
    assign fire        = in_valid & in_ready;

    // The core samples its operands in the accept cycle, so drive them directly.
    assign op         = bmat_op_e'(in_xor);
    assign core_xoren = fire & (op == BMAT_XOR);
    assign core_rs1   = fire ? in_rs1 : '0;
    assign core_rs2   = fire ? in_rs2 : '0;

    // One-stage pipe that marks which cycle carries a valid core result and
    // which tag belongs to it. Clearing issue_q on reset discards a result that
    // the core returns right after reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            issue_q <= 1'b0;
            tag_q   <= '0;
        end else begin
            issue_q <= fire;
            tag_q   <= in_tag;
        end
    end

    bmat_res_fifo #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_res_fifo (
        .clock       (clock),
        .reset       (reset),
        .push_i      (issue_q),
        .pop_i       (pop),
        .push_data_i ({core_rd, tag_q}),
        .count_o     (count),
        .head_o      (head)
    );

    // Outputs are masked during reset so nothing left over from before the
    // reset is visible while it is being held.
    assign has_data  = ~reset & (count != '0);
    assign out_valid = has_data;
    assign pop       = out_valid & out_ready;
    assign out_rd    = has_data ? head[W-1:TAG_W] : '0;
    assign out_tag   = has_data ? head[TAG_W-1:0] : '0;
    assign busy      = ~reset & (issue_q | (count != '0));

endmodule

// File: tb/tb_bmat_issue_wb.sv
// Testbench: tb_bmat_issue_wb
// Purpose: self-checking bench for bmat_issue_wb. A behavioural core model
//          answers the DUT's core port one cycle later; a queue-based reference
//          model tracks what the stage should hold and compares every output on
//          every cycle.
module tb_bmat_issue_wb;
    import bmat_pkg::*;

    localparam int DEPTH = 4;
    localparam int TAG_W = 5;
    localparam logic [63:0] IDENT = 64'h8040201008040201;

    logic             clock;
    logic             reset    = 1'b1;
    logic             in_valid = 1'b1;
    logic             in_ready;
    logic             in_xor   = 1'b0;
    logic [63:0]      in_rs1   = '0;
    logic [63:0]      in_rs2   = '0;
    logic [TAG_W-1:0] in_tag   = '0;
    logic             core_xoren;
    logic [63:0]      core_rs1;
    logic [63:0]      core_rs2;
    logic [63:0]      core_rd  = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [63:0]      out_rd;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    int        checks    = 0;
    int        errors    = 0;
    int        fireCount = 0;
    bmat_res_t modelQ[$];
    bit        pendValid = 1'b0;
    bmat_res_t pendItem  = '0;

    bmat_issue_wb #(.TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_xor     (in_xor),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_tag     (in_tag),
        .core_xoren (core_xoren),
        .core_rs1   (core_rs1),
        .core_rs2   (core_rs2),
        .core_rd    (core_rd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_rd     (out_rd),
        .out_tag    (out_tag),
        .busy       (busy)
    );

    // Free-running clock, first rising edge at 5.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Bit-matrix product: rd[i][j] = reduce_k (A[i][k] & B[k][j]), where row i
    // is byte i. Reduction is parity for bmatxor and OR for bmator.
    function automatic logic [63:0] bmatRef(input logic isXor, input logic [63:0] a,
                                            input logic [63:0] b);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                logic acc;
                acc = 1'b0;
                for (int k = 0; k < 8; k++) begin
                    if (isXor) acc = acc ^ (a[i*8+k] & b[k*8+j]);
                    else       acc = acc | (a[i*8+k] & b[k*8+j]);
                end
                r[i*8+j] = acc;
            end
        end
        return r;
    endfunction

    // Stand-in for the registered core: one cycle from operands to rd.
    always @(posedge clock) begin
        core_rd <= bmatRef(core_xoren, core_rs1, core_rs2);
    end

    task automatic checkOutput(input string name, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", name, observed, expected);
        end
    endtask

    // Drives one cycle of inputs, checks every output against the reference
    // model mid-cycle, then advances the model across the rising edge.
    task automatic applyStimulus(input bit rst, input bit v, input bit x,
                                 input logic [63:0] a, input logic [63:0] b,
                                 input logic [TAG_W-1:0] t, input bit ordy);
        bit        expReady;
        bit        expValid;
        bit        fire;
        bit        pop;
        bmat_res_t head;
        @(negedge clock);
        reset     = rst;
        in_valid  = v;
        in_xor    = x;
        in_rs1    = a;
        in_rs2    = b;
        in_tag    = t;
        out_ready = ordy;
        #1;
        expReady = !rst && ((modelQ.size() + int'(pendValid)) < DEPTH);
        expValid = !rst && (modelQ.size() != 0);
        head     = expValid ? modelQ[0] : '0;
        fire     = v && expReady;
        pop      = expValid && ordy;
        checkOutput("in_ready",   64'(in_ready),   64'(expReady));
        checkOutput("out_valid",  64'(out_valid),  64'(expValid));
        checkOutput("out_rd",     out_rd,          head.rd);
        checkOutput("out_tag",    64'(out_tag),    64'(head.tag));
        checkOutput("busy",       64'(busy),       64'(!rst && (pendValid || modelQ.size() != 0)));
        checkOutput("core_xoren", 64'(core_xoren), 64'(fire && x));
        checkOutput("core_rs1",   core_rs1,        fire ? a : 64'd0);
        checkOutput("core_rs2",   core_rs2,        fire ? b : 64'd0);
        if (v && in_ready === 1'b1) fireCount++;
        @(posedge clock);
        if (rst) begin
            modelQ.delete();
            pendValid = 1'b0;
        end else begin
            if (pop) void'(modelQ.pop_front());
            if (pendValid) modelQ.push_back(pendItem);
            pendValid = fire;
            if (fire) pendItem = '{rd: bmatRef(x, a, b), tag: t};
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    initial begin
        // Reset held with a request pending; nothing may be accepted or shown.
        repeat (3) applyStimulus(1, 1, 1, rnd64(), rnd64(), 5'd7, 1);
        applyStimulus(0, 0, 0, '0, '0, '0, 1);

        // Identity matrices through both reduce flavours.
        applyStimulus(0, 1, 1, IDENT, IDENT, 5'd3, 1);
        repeat (3) applyStimulus(0, 0, 0, '0, '0, '0, 1);
        applyStimulus(0, 1, 0, IDENT, IDENT, 5'd3, 1);
        repeat (3) applyStimulus(0, 0, 0, '0, '0, '0, 1);

        // Back-to-back stream with the writeback always ready.
        fireCount = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(0, 1, 1'($urandom_range(1)), rnd64(), rnd64(), TAG_W'(i), 1);
        end
        checkOutput("stream_fires", 64'(fireCount), 64'd20);
        repeat (3) applyStimulus(0, 0, 0, '0, '0, '0, 1);

        // Backpressure: only DEPTH requests may be accepted, then drain in order.
        fireCount = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 1, 0, rnd64(), rnd64(), TAG_W'(i + 8), 0);
        end
        checkOutput("fill_fires", 64'(fireCount), 64'(DEPTH));
        repeat (DEPTH + 2) applyStimulus(0, 0, 0, '0, '0, '0, 1);
        applyStimulus(0, 1, 1, rnd64(), rnd64(), 5'd30, 1);
        repeat (3) applyStimulus(0, 0, 0, '0, '0, '0, 1);

        // Push and pop together while DEPTH-1 results are buffered.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 1, rnd64(), rnd64(), TAG_W'(i + 16), 0);
        end
        applyStimulus(0, 0, 0, '0, '0, '0, 1);
        applyStimulus(0, 0, 0, '0, '0, '0, 0);
        repeat (6) applyStimulus(0, 0, 0, '0, '0, '0, 1);

        // Reset lands the cycle after an accept; the core result must vanish.
        applyStimulus(0, 1, 1, rnd64(), rnd64(), 5'd9, 1);
        applyStimulus(1, 0, 0, '0, '0, '0, 1);
        applyStimulus(0, 1, 0, IDENT, rnd64(), 5'd21, 1);
        repeat (4) applyStimulus(0, 0, 0, '0, '0, '0, 1);

        // Random traffic with random backpressure.
        for (int i = 0; i < 200; i++) begin
            applyStimulus(0, 1'($urandom_range(9) < 7), 1'($urandom_range(1)),
                          rnd64(), rnd64(), TAG_W'(i), 1'($urandom_range(1)));
        end
        repeat (8) applyStimulus(0, 0, 0, '0, '0, '0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
